// File: rtl/invert_pkg.sv
// Shared defaults for the bit-serial negator and its framing counter.
package invert_pkg;
   localparam int unsigned DEF_WORD_LEN = 0;
   localparam int unsigned DEF_CNT_W    = 16;
endpackage

// File: rtl/invert_bitcnt.sv
// Framing counter: strobes last on the final bit of each WORD_LEN-bit word.
// Zero latency on the strobe; no backpressure, advances every clock out of reset.
module invert_bitcnt
   import invert_pkg::*;
#(
   parameter int unsigned WORD_LEN = 4,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic t_clk,
   input  logic r,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_LEN - 1);

   logic [CNT_W-1:0] cnt;

   assign last = (cnt == LAST_IDX);

   always_ff @(posedge t_clk or negedge r) begin
      if (!r) begin
         cnt <= '0;
      end else if (last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first: copy up to the first 1, invert after.
// Zero latency (combinational output); no backpressure, one bit per clock.
module invert
   import invert_pkg::*;
#(
   parameter int unsigned WORD_LEN = DEF_WORD_LEN,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic i,
   input  logic r,
   input  logic t_clk,
   output logic y
);

   logic seen;
   logic word_last;

   generate
      if (WORD_LEN > 0) begin : g_framed
         invert_bitcnt #(
            .WORD_LEN (WORD_LEN),
            .CNT_W    (CNT_W)
         ) u_bitcnt (
            .t_clk (t_clk),
            .r     (r),
            .last  (word_last)
         );
      end else begin : g_unframed
         assign word_last = 1'b0;
      end
   endgenerate

   // Gating with r keeps y low for the whole reset, independent of i.
   assign y = r & (i ^ seen);

   always_ff @(posedge t_clk or negedge r) begin
      if (!r) begin
         seen <= 1'b0;
      end else if (word_last) begin
         seen <= 1'b0;
      end else begin
         seen <= seen | i;
      end
   end

endmodule

// File: tb/tb_invert.sv
module tb_invert;

   logic t_clk;
   logic r;
   logic i;
   logic y_u;
   logic y_f;

   int checks;
   int failures;

   // Reference model: accumulated operand value and bit position of the current word.
   logic [63:0] mv_u;
   logic [63:0] mv_f;
   int          pos_u;
   int          pos_f;

   invert #(.WORD_LEN(0)) u_unf (.i(i), .r(r), .t_clk(t_clk), .y(y_u));
   invert #(.WORD_LEN(4)) u_frm (.i(i), .r(r), .t_clk(t_clk), .y(y_f));

   initial begin
      t_clk = 1'b0;
      forever #5 t_clk = ~t_clk;
   end

   // Bit pos of -(operand so far) depends only on operand bits 0..pos.
   function automatic bit neg_bit(logic [63:0] v, int pos, bit b);
      logic [63:0] t;
      t      = v;
      t[pos] = b;
      t      = -t;
      return t[pos];
   endfunction

   task automatic model_reset();
      mv_u  = '0;
      mv_f  = '0;
      pos_u = 0;
      pos_f = 0;
   endtask

   // Entered and left at posedge+1; drives one bit, checks both DUTs at negedge.
   task automatic apply_bit(input bit b, output bit yu, output bit yf);
      bit eu, ef;
      i  = b;
      eu = neg_bit(mv_u, pos_u, b);
      ef = neg_bit(mv_f, pos_f, b);
      @(negedge t_clk);
      yu = y_u;
      yf = y_f;
      checks++;
      if (y_u !== eu) begin
         failures++;
         $display("FAIL model_unframed pos=%0d i=%b got=%b exp=%b", pos_u, b, y_u, eu);
      end
      checks++;
      if (y_f !== ef) begin
         failures++;
         $display("FAIL model_framed pos=%0d i=%b got=%b exp=%b", pos_f, b, y_f, ef);
      end
      mv_u[pos_u] = b;
      pos_u++;
      mv_f[pos_f] = b;
      pos_f++;
      if (pos_f == 4) begin
         pos_f = 0;
         mv_f  = '0;
      end
      @(posedge t_clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      r = 1'b0;
      model_reset();
      for (int k = 0; k < n; k++) begin
         i = 1'($urandom);
         @(negedge t_clk);
         checks++;
         if (y_u !== 1'b0 || y_f !== 1'b0) begin
            failures++;
            $display("FAIL reset_low cyc=%0d got=%b%b exp=00", k, y_u, y_f);
         end
         @(posedge t_clk);
         #1;
      end
      r = 1'b1;
   endtask

   task automatic run_seq(input string name, input int n, input bit seq[16],
                          input bit exp[16], input bit framed);
      bit yu, yf, got;
      for (int k = 0; k < n; k++) begin
         apply_bit(seq[k], yu, yf);
         got = framed ? yf : yu;
         checks++;
         if (got !== exp[k]) begin
            failures++;
            $display("FAIL %s bit=%0d got=%b exp=%b", name, k, got, exp[k]);
         end
      end
   endtask

   task automatic test_reset();
      bit yu, yf;
      r = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         i = k[0];
         @(negedge t_clk);
         checks++;
         if (y_u !== 1'b0 || y_f !== 1'b0) begin
            failures++;
            $display("FAIL test_reset hold=%0d got=%b%b exp=00", k, y_u, y_f);
         end
         @(negedge t_clk);
         i = ~i;
         #1;
         checks++;
         if (y_u !== 1'b0) begin
            failures++;
            $display("FAIL test_reset toggle=%0d got=%b exp=0", k, y_u);
         end
         @(posedge t_clk);
         #1;
      end
      r = 1'b1;
      apply_bit(1'b1, yu, yf);
      checks++;
      if (yu !== 1'b1 || yf !== 1'b1) begin
         failures++;
         $display("FAIL test_reset first_one got=%b%b exp=11", yu, yf);
      end
   endtask

   task automatic test_unframed();
      bit s[16] = '{0,0,1,0,1,1, 0,0,0,0,0,0,0,0,0,0};
      bit e[16] = '{0,0,1,1,0,0, 0,0,0,0,0,0,0,0,0,0};
      do_reset(1);
      run_seq("unframed_52", 6, s, e, 1'b0);
   endtask

   task automatic test_edges();
      bit s0[16] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0};
      bit s8[16] = '{0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0,0};
      do_reset(1);
      run_seq("zero_unframed", 4, s0, s0, 1'b0);
      do_reset(1);
      run_seq("minneg_unframed", 4, s8, s8, 1'b0);
      do_reset(1);
      run_seq("minneg_framed", 4, s8, s8, 1'b1);
   endtask

   task automatic test_sticky();
      bit s[16] = '{1,0,0,0,1,1, 0,0,0,0,0,0,0,0,0,0};
      bit e[16] = '{1,1,1,1,0,0, 0,0,0,0,0,0,0,0,0,0};
      bit z[16] = '{0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0};
      do_reset(1);
      run_seq("sticky", 6, s, e, 1'b0);
      do_reset(1);
      run_seq("sticky_rearm", 2, z, z, 1'b0);
   endtask

   task automatic test_framed();
      bit s[16] = '{1,0,1,1, 0,1,0,0, 0,0,0,1, 0,0,1,0};
      bit e[16] = '{1,1,0,0, 0,1,1,1, 0,0,0,1, 0,0,1,1};
      do_reset(1);
      run_seq("framed_w4", 16, s, e, 1'b1);
   endtask

   task automatic test_async_reset();
      bit s[16] = '{0,1, 0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      bit yu, yf;
      do_reset(1);
      apply_bit(1'b1, yu, yf);
      apply_bit(1'b0, yu, yf);
      i = 1'b0;
      #1;
      checks++;
      if (y_u !== 1'b1) begin
         failures++;
         $display("FAIL async_pre got=%b exp=1", y_u);
      end
      r = 1'b0;
      #1;
      checks++;
      if (y_u !== 1'b0 || y_f !== 1'b0) begin
         failures++;
         $display("FAIL async_drop got=%b%b exp=00", y_u, y_f);
      end
      model_reset();
      @(posedge t_clk);
      #1;
      r = 1'b1;
      run_seq("async_restart_u", 2, s, s, 1'b0);
   endtask

   task automatic test_random();
      bit yu, yf;
      for (int k = 0; k < 300; k++) begin
         if (k % 40 == 0 || $urandom_range(0, 24) == 0) do_reset($urandom_range(1, 2));
         apply_bit(1'($urandom), yu, yf);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      r        = 1'b0;
      i        = 1'b0;
      model_reset();
      @(posedge t_clk);
      #1;
      test_reset();
      test_unframed();
      test_edges();
      test_sticky();
      test_framed();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
